// File: rtl/seq_multiplier_nx_if.sv
// Handshake bundle for seq_multiplier_nx: operand request channel, product response channel, busy.
// Both builds (SEQMUL_SIGNED_EN defined or not) use this same interface.
interface seq_multiplier_nx_if #(
    parameter int unsigned N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/seq_multiplier_nx.sv
// Iterative shift-add multiplier: one partial product per clock, N cycles per result, held until taken.
// Define SEQMUL_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_multiplier_nx #(
    parameter int unsigned N = 4
) (
    input logic               clk,
    input logic               res,
    seq_multiplier_nx_if.slave bus
);
    localparam int unsigned W    = 2 * N;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    mcand_q;
    logic [N-1:0]    mplier_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    product_q;
    logic [CntW-1:0] count_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            out_valid_q;

    logic            last_step;
    logic [W-1:0]    acc_d;
    logic [W-1:0]    mcand_ext;

    always_comb begin
        last_step = (count_q == CntW'(N - 1));
`ifdef SEQMUL_SIGNED_EN
        mcand_ext = {{N{bus.a[N-1]}}, bus.a};
`else
        mcand_ext = {{N{1'b0}}, bus.a};
`endif
    end

    // On the last step of a signed multiply the multiplier LSB is b's sign bit, weight -2^(N-1).
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
`ifdef SEQMUL_SIGNED_EN
            if (last_step) begin
                acc_d = acc_q - mcand_q;
            end else begin
                acc_d = acc_q + mcand_q;
            end
`else
            acc_d = acc_q + mcand_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        mcand_q    <= mcand_ext;
                        mplier_q   <= bus.b;
                        acc_q      <= '0;
                        count_q    <= '0;
                        state_q    <= StBusy;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StBusy: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (last_step) begin
                        product_q   <= acc_d;
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    // product_q is deliberately kept after acceptance
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_nx.sv
// Self-checking bench for seq_multiplier_nx (N=4 main instance, N=8 secondary instance).
// Expected values follow SEQMUL_SIGNED_EN when it is defined at compile time.
module tb_seq_multiplier_nx;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_multiplier_nx_if #(.N(N)) bus ();
    seq_multiplier_nx_if #(.N(8)) bus8 ();

    seq_multiplier_nx #(.N(N)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    seq_multiplier_nx #(.N(8)) dut8 (
        .clk (clk),
        .res (res),
        .bus (bus8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of the operand values, reduced to 2n bits.
    function automatic logic [31:0] model_mul(input int unsigned av, input int unsigned bv,
                                              input int n);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(av);
        sb = longint'(bv);
`ifdef SEQMUL_SIGNED_EN
        if (av >= (32'd1 << (n - 1))) sa = sa - (longint'(1) << n);
        if (bv >= (32'd1 << (n - 1))) sb = sb - (longint'(1) << n);
`endif
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    // Transaction-level model: phase 0 idle, 1 busy (N cycles), 2 done.
    int         m_ph = 0;
    int         m_k = 0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_prod = '0;

    always @(posedge clk or posedge res) begin
        if (res) begin
            m_ph   = 0;
            m_prod = '0;
        end else begin
            case (m_ph)
                0: if (bus.in_valid) begin
                    m_pend = 8'(model_mul(bus.a, bus.b, N));
                    m_k    = 0;
                    m_ph   = 1;
                end
                1: begin
                    m_k++;
                    if (m_k == N) begin
                        m_ph   = 2;
                        m_prod = m_pend;
                    end
                end
                default: if (bus.out_ready) m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cycle_ready_busy_valid_product",
              32'({bus.in_ready, bus.busy, bus.out_valid, bus.product}),
              32'({m_ph == 0, m_ph == 1, m_ph == 2, m_prod}));
    end

    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input int stall,
                          output logic [7:0] p);
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.a         = ai;
        bus.b         = bi;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, N);
        p = bus.product;
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check("stall_hold", 32'({bus.out_valid, bus.in_ready, bus.product}),
                      32'({1'b1, 1'b0, p}));
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            check("stall_release", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
        end
    endtask

    initial begin
        logic [7:0] p;
        int         lat;
        bit         seen;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.out_ready = 1'b1;
        #1 res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.product}),
              32'({1'b1, 1'b0, 1'b0, 8'h00}));
        res = 1'b0;

`ifdef SEQMUL_SIGNED_EN
        check("model_m8xm8", model_mul(8, 8, 4), 32'h40);
        check("model_m1x7", model_mul(15, 7, 4), 32'hF9);
        check("model_7xm8", model_mul(7, 8, 4), 32'hC8);
        check("model_n8", model_mul(255, 255, 8), 32'h0001);
`else
        check("model_15x15", model_mul(15, 15, 4), 32'hE1);
        check("model_2x5", model_mul(2, 5, 4), 32'h0A);
        check("model_n8", model_mul(255, 255, 8), 32'hFE01);
`endif

        run_op(4'd15, 4'd15, 0, p);
`ifdef SEQMUL_SIGNED_EN
        check("p_15x15", p, 32'h01);
        run_op(4'd8, 4'd8, 0, p);
        check("p_m8xm8", p, 32'h40);
        run_op(4'd15, 4'd7, 0, p);
        check("p_m1x7", p, 32'hF9);
        run_op(4'd7, 4'd8, 0, p);
        check("p_7xm8", p, 32'hC8);
`else
        check("p_15x15", p, 32'hE1);
`endif

        for (int i = 0; i < 256; i++) begin
            run_op(4'(i >> 4), 4'(i), 0, p);
            check("sweep", p, model_mul(i >> 4, i & 15, 4));
        end

        run_op(4'd9, 4'd6, 5, p);
        check("backpressure_product", p, model_mul(9, 6, 4));

        // in_valid pulsed mid-BUSY must not be captured
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = 4'd2;
        bus.b = 4'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = 4'd3;
        bus.b = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_product", bus.product, 32'h0A);
        repeat (2) @(posedge clk);
        #1;
        check("ignore_no_capture", 32'({bus.in_ready, bus.busy}), 32'(2'b10));

        // reset two cycles into BUSY
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = 4'd7;
        bus.b = 4'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", bus.busy, 1'b1);
        res = 1'b1;
        #1;
        check("midbusy_reset", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.product}),
              32'({1'b1, 1'b0, 1'b0, 8'h00}));
        @(posedge clk); #1;
        res = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_result_after_reset", seen, 1'b0);

        // N=8 instance
        @(posedge clk); #1;
        bus8.in_valid = 1'b1;
        bus8.a = 8'd255;
        bus8.b = 8'd255;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n8_latency", lat, 8);
`ifdef SEQMUL_SIGNED_EN
        check("n8_product", bus8.product, 32'h0001);
`else
        check("n8_product", bus8.product, 32'hFE01);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
